// File: rtl/bwzz_interrupt_controller_pkg.sv
// Shared types and sizing helpers for the interrupt controller slice.
package bwzz_interrupt_controller_pkg;

    // Controller phases: idle, pulse on the interrupt wire, waiting for ISR entry, ISR running.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ASSERT     = 2'd1,
        WAIT_ACK   = 2'd2,
        IN_SERVICE = 2'd3
    } irqState_t;

    // Width of an irq index.
    function automatic int idWidth(input int numIrq);
        return (numIrq < 2) ? 1 : $clog2(numIrq);
    endfunction

    // Width of the phase counter; it must reach max(pulseLen, ackTimeout) - 1.
    function automatic int cntWidth(input int pulseLen, input int ackTimeout);
        int m;
        m = (pulseLen > ackTimeout) ? pulseLen : ackTimeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bwzz_interrupt_controller_if.sv
// Request/acknowledge bundle between the interrupt sources, the core and the controller.
interface bwzz_interrupt_controller_if
    import bwzz_interrupt_controller_pkg::*;
#(
    parameter int NUM_IRQ = 4
) ();
    localparam int ID_W = idWidth(NUM_IRQ);

    logic [NUM_IRQ-1:0] irqIn;
    logic               maskWe;
    logic [NUM_IRQ-1:0] maskData;
    logic               intAck;
    logic               intRet;
    logic               errClr;
    logic               interrupt;
    logic [31:0]        irqVector;
    logic [ID_W-1:0]    irqId;
    logic               inService;
    logic [NUM_IRQ-1:0] pending;
    logic               timeoutErr;

    // Source/core side.
    modport master (
        output irqIn, maskWe, maskData, intAck, intRet, errClr,
        input  interrupt, irqVector, irqId, inService, pending, timeoutErr
    );

    // Controller side.
    modport slave (
        input  irqIn, maskWe, maskData, intAck, intRet, errClr,
        output interrupt, irqVector, irqId, inService, pending, timeoutErr
    );
endinterface

// File: rtl/bwzz_interrupt_controller_irq_priority_encoder.sv
// Fixed-priority pick: lowest set index of the eligible vector wins.
module irq_priority_encoder #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_IRQ-1:0] eligible,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);
    assign valid = |eligible;

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) idx = ID_W'(i);
        end
    end
endmodule

// File: rtl/bwzz_interrupt_controller.sv
// Single-wire interrupt source: edge capture, masking, priority grant,
// fixed-length pulse to the core and ack/return tracking.
module bwzz_interrupt_controller
    import bwzz_interrupt_controller_pkg::*;
#(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0010,
    parameter int          VEC_STRIDE  = 2,
    parameter int          PULSE_LEN   = 1,
    parameter int          ACK_TIMEOUT = 16
) (
    input logic clk,
    input logic reset,
    bwzz_interrupt_controller_if.slave bus
);
    localparam int ID_W  = idWidth(NUM_IRQ);
    localparam int CNT_W = cntWidth(PULSE_LEN, ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);

    irqState_t          state, stateNext;
    logic [NUM_IRQ-1:0] irqPrev, mask, pend;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    grantId;
    logic [31:0]        vecReg;
    logic               errReg;
    logic               winValid, grant, timeout;
    logic [ID_W-1:0]    winId;
    logic [NUM_IRQ-1:0] eligible, pendSet, pendClr;

    assign eligible = pend & ~mask;

    irq_priority_encoder #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) uEnc (
        .eligible(eligible),
        .valid   (winValid),
        .idx     (winId)
    );

    // Next phase; ack beats the pulse/timeout expiry in the same cycle.
    always_comb begin
        stateNext = state;
        grant     = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: if (winValid) begin
                grant     = 1'b1;
                stateNext = ASSERT;
            end
            ASSERT: begin
                if (bus.intAck)            stateNext = IN_SERVICE;
                else if (cnt == PULSE_LAST) stateNext = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.intAck) stateNext = IN_SERVICE;
                else if (cnt == ACK_LAST) begin
                    stateNext = IDLE;
                    timeout   = 1'b1;
                end
            end
            IN_SERVICE: if (bus.intRet) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Phase register and per-phase cycle counter (restarts on every phase change).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            if (stateNext != state)                   cnt <= '0;
            else if (state inside {ASSERT, WAIT_ACK}) cnt <= cnt + 1'b1;
        end
    end

    // Grant id/vector are held from grant until the controller is back in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grantId <= '0;
            vecReg  <= '0;
        end else if (grant) begin
            grantId <= winId;
            vecReg  <= VEC_BASE + 32'(winId) * 32'(VEC_STRIDE);
        end else if (stateNext == IDLE) begin
            grantId <= '0;
            vecReg  <= '0;
        end
    end

    // A timed-out grant is put back into pending so it is re-raised.
    assign pendSet = (bus.irqIn & ~irqPrev) | (timeout ? (NUM_IRQ'(1) << grantId) : '0);
    assign pendClr = grant ? (NUM_IRQ'(1) << winId) : '0;

    // Edge capture, pending (set wins over clear), mask and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqPrev <= '0;
            pend    <= '0;
            mask    <= '0;
            errReg  <= 1'b0;
        end else begin
            irqPrev <= bus.irqIn;
            pend    <= (pend & ~pendClr) | pendSet;
            if (bus.maskWe) mask <= bus.maskData;
            if (timeout)         errReg <= 1'b1;
            else if (bus.errClr) errReg <= 1'b0;
        end
    end

    assign bus.interrupt  = (state == ASSERT);
    assign bus.inService  = (state == IN_SERVICE);
    assign bus.irqId      = grantId;
    assign bus.irqVector  = vecReg;
    assign bus.pending    = pend;
    assign bus.timeoutErr = errReg;
endmodule

// File: doc/bwzz_interrupt_controller.md
Name: bwzz_interrupt_controller

Overview:
Source side of the core's single-wire interrupt protocol. It collects up to NUM_IRQ external requests and prioritises them. It drives the core's `interrupt` input as a fixed-length pulse and supplies the handler vector. It then tracks the core's acknowledge (ISR entry) and return (RTI) so that exactly one interrupt is in service at a time. It sits beside the processor top and feeds that top's `interrupt` pin.

Parameters:
NUM_IRQ, 4, number of request lines (2..8)
VEC_BASE, 32'h0000_0010, handler address for irq 0
VEC_STRIDE, 2, address spacing between consecutive handler entries
PULSE_LEN, 1, cycles `interrupt` is held high (1..4)
ACK_TIMEOUT, 16, cycles to wait for intAck after the pulse before abandoning (>=2)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
irqIn  in  NUM_IRQ  raw request lines, rising-edge sensitive, synchronous to clk
maskWe  in  1  write enable for the mask register
maskData  in  NUM_IRQ  new mask value; 1 = line disabled
intAck  in  1  core pulse: first ISR instruction has entered decode
intRet  in  1  core pulse: RTI of the ISR has committed
errClr  in  1  clears timeoutErr
interrupt  out  1  to the core's interrupt input
irqVector  out  32  handler address of the granted irq
irqId  out  $clog2(NUM_IRQ)  index of the granted irq
inService  out  1  high while the ISR is executing
pending  out  NUM_IRQ  latched, not-yet-granted requests
timeoutErr  out  1  sticky flag: an ack timeout occurred

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, mask 0 (all lines enabled), irqPrev 0, counters 0. Asserting reset mid-pulse drops `interrupt` immediately. Any in-service or pending request is lost.
- Edge capture: irqPrev <= irqIn each cycle. A rising edge (irqIn & ~irqPrev) sets the corresponding pending bit. Masked lines still latch into pending but are not eligible for grant. If a set and a grant-clear hit the same bit in the same cycle, the set wins.
- Mask: on maskWe, mask <= maskData. The new mask is visible to arbitration on the next cycle. A mask write never affects a grant already in flight.
- Eligibility: pending & ~mask. Fixed priority: the lowest index wins.
- FSM states:
  - IDLE: if any line is eligible, latch irqId = winner, register irqVector = VEC_BASE + irqId*VEC_STRIDE (32-bit, wraps modulo 2^32), clear that pending bit, then go to ASSERT. Otherwise stay in IDLE.
  - ASSERT: `interrupt` = 1 for exactly PULSE_LEN cycles, counted from ASSERT entry, then go to WAIT_ACK. If intAck arrives during ASSERT, go directly to IN_SERVICE; `interrupt` is 0 from the next cycle.
  - WAIT_ACK: `interrupt` = 0. On intAck, go to IN_SERVICE. After ACK_TIMEOUT cycles without intAck: set timeoutErr, re-set pending[irqId], and go to IDLE.
  - IN_SERVICE: inService = 1. intAck is ignored. On intRet, go to IDLE.
- intRet in any state other than IN_SERVICE is ignored.
- After leaving IN_SERVICE, the controller spends at least one cycle in IDLE before the next ASSERT. Back-to-back interrupts are therefore spaced by at least one cycle.
- Nesting is not supported. New edges arriving during ASSERT, WAIT_ACK or IN_SERVICE only accumulate in pending.
- irqId and irqVector hold their values from grant until the return to IDLE. They read 0 in IDLE.
- timeoutErr is sticky. errClr clears it; if errClr and a timeout occur in the same cycle, the timeout wins.
- Latency: a rising edge on an enabled line in IDLE produces `interrupt` = 1 two cycles later (one cycle for the edge register, one for the grant register).

Decomposition:
- Shared include holds:
  - state encoding localparams: IDLE = 2'd0, ASSERT = 2'd1, WAIT_ACK = 2'd2, IN_SERVICE = 2'd3;
  - ID width = $clog2(NUM_IRQ);
  - counter width sized for max(PULSE_LEN, ACK_TIMEOUT).
- One sub-module, irq_priority_encoder: purely combinational. Takes the eligible vector and outputs a valid flag and the lowest set index.
- The FSM, counters, edge capture and mask live in the top module.

Test Plan:
- Reset mid-pulse: with PULSE_LEN = 3, assert reset in the second pulse cycle -> `interrupt` drops the same cycle, and all outputs are 0 after reset.
- Single request: rising edge on irqIn[2], intAck 3 cycles later, intRet 10 cycles later -> `interrupt` pulses 1 cycle at t+2; irqId = 2 and irqVector = 32'h14 from grant; inService is high between ack and ret, then IDLE.
- Simultaneous edges on irqIn[3] and irqIn[1] -> irq 1 is granted first (vector 32'h12) and pending = 4'b1000. After intRet, irq 3 asserts no earlier than one IDLE cycle later (vector 32'h16).
- Mask: with maskData = 4'b0001 written, an edge on irqIn[0] -> pending[0] = 1 and there is no interrupt. After maskData = 0 is written, the interrupt asserts with irqId = 0.
- Timeout: no intAck for 16 cycles after the pulse -> timeoutErr = 1, the pending bit is restored, and the request is re-raised from IDLE. errClr then returns timeoutErr to 0.
- Early ack and spurious return: intAck in the first ASSERT cycle with PULSE_LEN = 3 -> `interrupt` is low on the next cycle and state is IN_SERVICE. intRet while in IDLE -> no state change.
